// File: rtl/fetch_pkg.sv
`default_nettype none
//==============================================================================
// fetch_pkg : shared widths, memory timeout default and fetch state encoding
// Rev 1.0
//==============================================================================
package fetch_pkg;

   localparam int unsigned c_AW_DEFAULT       = 15;
   localparam int unsigned c_DW_DEFAULT       = 16;
   localparam int unsigned c_MAX_WAIT_DEFAULT = 15;

   typedef enum logic [2:0] {
      ST_IDLE = 3'd0,
      ST_REQ  = 3'd1,
      ST_WAIT = 3'd2,
      ST_HOLD = 3'd3,
      ST_HALT = 3'd4
   } fetch_state_t;

endpackage
`default_nettype wire

// File: rtl/fetch_ctrl_if.sv
`default_nettype none
//==============================================================================
// fetch_ctrl_if : PC, instruction memory, decode and branch signals of fetch_ctrl
// Rev 1.0
//==============================================================================
interface fetch_ctrl_if
   import fetch_pkg::*;
#(
   parameter int unsigned AW = c_AW_DEFAULT,
   parameter int unsigned DW = c_DW_DEFAULT
);

   logic [AW-1:0] pc_addr;
   logic          pc_inc;
   logic          pc_re;
   logic [AW-1:0] pc_load_addr;
   logic          mem_rd;
   logic [AW-1:0] mem_addr;
   logic          mem_ready;
   logic [DW-1:0] mem_data;
   logic [DW-1:0] ir;
   logic          ir_valid;
   logic          ir_ready;
   logic          br_taken;
   logic [AW-1:0] br_target;
   logic          fetch_err;

   modport master (
      input  pc_addr, mem_ready, mem_data, ir_ready, br_taken, br_target,
      output pc_inc, pc_re, pc_load_addr, mem_rd, mem_addr, ir, ir_valid, fetch_err
   );

   modport slave (
      output pc_addr, mem_ready, mem_data, ir_ready, br_taken, br_target,
      input  pc_inc, pc_re, pc_load_addr, mem_rd, mem_addr, ir, ir_valid, fetch_err
   );

endinterface
`default_nettype wire

// File: rtl/fetch_wait_timer.sv
`default_nettype none
//==============================================================================
// fetch_wait_timer : counts memory wait cycles and flags the timeout cycle
// Rev 1.0
//==============================================================================
module fetch_wait_timer
   import fetch_pkg::*;
#(
   parameter int unsigned MAX_WAIT = c_MAX_WAIT_DEFAULT
)(
   input  wire  clk,
   input  wire  rst,
   input  wire  clr,
   input  wire  en,
   output logic expired
);

   localparam int unsigned CW = $clog2(MAX_WAIT + 1);

   logic [CW-1:0] count_q;
   logic [CW-1:0] count_d;

   always_comb begin
      count_d = count_q;
      if (clr) begin
         count_d = '0;
      end else if (en) begin
         count_d = count_q + 1'b1;
      end
   end

   // Fires in the cycle whose increment would bring the count to MAX_WAIT.
   assign expired = en && (count_q == CW'(MAX_WAIT - 1));

   always_ff @(posedge clk) begin
      if (rst) begin
         count_q <= '0;
      end else begin
         count_q <= count_d;
      end
   end

endmodule
`default_nettype wire

// File: rtl/fetch_ctrl.sv
`default_nettype none
//==============================================================================
// fetch_ctrl : fetches instructions at the PC into a handshaked instruction reg
// Rev 1.0
//==============================================================================
module fetch_ctrl
   import fetch_pkg::*;
#(
   parameter int unsigned AW       = c_AW_DEFAULT,
   parameter int unsigned DW       = c_DW_DEFAULT,
   parameter int unsigned MAX_WAIT = c_MAX_WAIT_DEFAULT
)(
   input  wire          clk,
   input  wire          rst,
   fetch_ctrl_if.master bus
);

   fetch_state_t  state_q, state_d;
   logic [DW-1:0] ir_q, ir_d;
   logic          ir_valid_q, ir_valid_d;
   logic [AW-1:0] mem_addr_q, mem_addr_d;
   logic          flush_q, flush_d;
   logic          fetch_err_q, fetch_err_d;

   logic          tmr_en;
   logic          tmr_clr;
   logic          tmr_expired;

   assign tmr_en  = (state_q == ST_WAIT) && !bus.mem_ready;
   assign tmr_clr = !tmr_en;

   fetch_wait_timer #(
      .MAX_WAIT (MAX_WAIT)
   ) u_wait_timer (
      .clk     (clk),
      .rst     (rst),
      .clr     (tmr_clr),
      .en      (tmr_en),
      .expired (tmr_expired)
   );

   always_comb begin
      state_d     = state_q;
      ir_d        = ir_q;
      mem_addr_d  = mem_addr_q;
      flush_d     = flush_q;
      fetch_err_d = fetch_err_q;

      case (state_q)
         ST_IDLE: begin
            state_d = ST_REQ;
         end
         ST_REQ: begin
            mem_addr_d = bus.pc_addr;
            if (bus.br_taken) begin
               state_d = ST_REQ;
            end else if (bus.mem_ready) begin
               ir_d    = bus.mem_data;
               state_d = ST_HOLD;
            end else begin
               state_d = ST_WAIT;
            end
         end
         ST_WAIT: begin
            if (bus.mem_ready) begin
               // Wrong-path data (flushed or redirected now) is dropped and refetched.
               if (!bus.br_taken && !flush_q) begin
                  ir_d    = bus.mem_data;
                  state_d = ST_HOLD;
               end else begin
                  state_d = ST_REQ;
               end
               flush_d = 1'b0;
            end else if (tmr_expired) begin
               fetch_err_d = 1'b1;
               flush_d     = 1'b0;
               state_d     = ST_HALT;
            end else if (bus.br_taken) begin
               flush_d = 1'b1;
            end
         end
         ST_HOLD: begin
            if (bus.br_taken || bus.ir_ready) begin
               state_d = ST_REQ;
            end
         end
         ST_HALT: begin
            state_d = ST_HALT;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase

      ir_valid_d = (state_d == ST_HOLD);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= ST_IDLE;
         ir_q        <= '0;
         ir_valid_q  <= 1'b0;
         mem_addr_q  <= '0;
         flush_q     <= 1'b0;
         fetch_err_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         ir_q        <= ir_d;
         ir_valid_q  <= ir_valid_d;
         mem_addr_q  <= mem_addr_d;
         flush_q     <= flush_d;
         fetch_err_q <= fetch_err_d;
      end
   end

   // REQ shows the live PC so a strobe on the entry edge is already reflected;
   // the captured copy holds the address steady through WAIT.
   assign bus.mem_addr     = (state_q == ST_REQ) ? bus.pc_addr : mem_addr_q;
   assign bus.mem_rd       = !rst && ((state_q == ST_REQ) || (state_q == ST_WAIT));
   assign bus.pc_re        = !rst && bus.br_taken && (state_q != ST_HALT);
   assign bus.pc_inc       = !rst && (state_q == ST_HOLD) && ir_valid_q
                             && bus.ir_ready && !bus.br_taken;
   assign bus.pc_load_addr = bus.br_taken ? bus.br_target : '0;
   assign bus.ir           = ir_q;
   assign bus.ir_valid     = ir_valid_q;
   assign bus.fetch_err    = fetch_err_q;

endmodule
`default_nettype wire

// File: tb/tb_fetch_ctrl.sv
`default_nettype none
//==============================================================================
// tb_fetch_ctrl : directed and random fetch traffic against a transaction model
// Rev 1.0
//==============================================================================
module tb_fetch_ctrl;

   localparam int AW       = 15;
   localparam int DW       = 16;
   localparam int MAX_WAIT = 15;

   logic clk;
   logic rst;

   fetch_ctrl_if #(.AW(AW), .DW(DW)) bus ();

   fetch_ctrl #(
      .AW       (AW),
      .DW       (DW),
      .MAX_WAIT (MAX_WAIT)
   ) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int total = 0;
   int bad   = 0;

   // stimulus knobs
   logic          ir_ready_v;
   logic          br_v;
   logic [AW-1:0] tgt_v;
   int            lat_cfg;

   // transaction-level model: PC, one outstanding read, instruction slot
   logic [AW-1:0] m_pc;
   logic [AW-1:0] m_addr;
   logic [DW-1:0] m_ir;
   bit            m_idle, m_active, m_first, m_doomed, m_have, m_halt, m_err;
   int            m_waited;
   int            cur_lat;

   function automatic logic [DW-1:0] mem_word(input logic [AW-1:0] a);
      if (a == 15'd5) return 16'hA5A5;
      return {a[7:0] ^ 8'h3C, a[14:7]};
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      total++;
      assert (obs === expv) else begin
         bad++;
         $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, expv);
      end
   endtask

   task automatic start_req();
      m_active = 1'b1;
      m_first  = 1'b1;
      m_waited = 0;
      m_doomed = 1'b0;
      cur_lat  = lat_cfg;
   endtask

   task automatic do_reset();
      rst              = 1'b1;
      bus.pc_addr      = m_pc;
      bus.mem_ready    = 1'b1;
      bus.mem_data     = 16'hDEAD;
      bus.br_taken     = 1'b1;
      bus.br_target    = 15'h1234;
      bus.ir_ready     = 1'b1;
      @(negedge clk);
      chk("rst_pc_inc_pre", {31'd0, bus.pc_inc}, 32'd0);
      chk("rst_pc_re_pre", {31'd0, bus.pc_re}, 32'd0);
      @(posedge clk); #1;
      @(negedge clk);
      chk("rst_mem_rd", {31'd0, bus.mem_rd}, 32'd0);
      chk("rst_mem_addr", {17'd0, bus.mem_addr}, 32'd0);
      chk("rst_ir", {16'd0, bus.ir}, 32'd0);
      chk("rst_ir_valid", {31'd0, bus.ir_valid}, 32'd0);
      chk("rst_fetch_err", {31'd0, bus.fetch_err}, 32'd0);
      chk("rst_pc_inc", {31'd0, bus.pc_inc}, 32'd0);
      chk("rst_pc_re", {31'd0, bus.pc_re}, 32'd0);
      @(posedge clk); #1;
      rst           = 1'b0;
      bus.mem_ready = 1'b0;
      bus.br_taken  = 1'b0;
      m_idle   = 1'b1;
      m_active = 1'b0;
      m_first  = 1'b0;
      m_doomed = 1'b0;
      m_have   = 1'b0;
      m_halt   = 1'b0;
      m_err    = 1'b0;
      m_waited = 0;
      m_ir     = '0;
      m_addr   = '0;
      cur_lat  = 0;
   endtask

   // One clock: drive inputs, check every output at the falling edge, advance model.
   task automatic cycle();
      logic          rdy;
      logic [DW-1:0] dat;
      logic [AW-1:0] req_addr;
      logic          e_inc;
      logic          e_re;
      logic [AW-1:0] e_load;

      req_addr = (m_active && m_first) ? m_pc : m_addr;
      rdy      = m_active && (m_waited >= cur_lat);
      dat      = rdy ? mem_word(req_addr) : DW'($urandom);
      e_re     = br_v && !m_halt;
      e_inc    = m_have && ir_ready_v && !br_v;
      e_load   = br_v ? tgt_v : '0;

      bus.pc_addr   = m_pc;
      bus.ir_ready  = ir_ready_v;
      bus.br_taken  = br_v;
      bus.br_target = tgt_v;
      bus.mem_ready = rdy;
      bus.mem_data  = dat;

      @(negedge clk);
      chk("mem_rd", {31'd0, bus.mem_rd}, {31'd0, m_active});
      chk("mem_addr", {17'd0, bus.mem_addr}, {17'd0, req_addr});
      chk("ir", {16'd0, bus.ir}, {16'd0, m_ir});
      chk("ir_valid", {31'd0, bus.ir_valid}, {31'd0, m_have});
      chk("fetch_err", {31'd0, bus.fetch_err}, {31'd0, m_err});
      chk("pc_inc", {31'd0, bus.pc_inc}, {31'd0, e_inc});
      chk("pc_re", {31'd0, bus.pc_re}, {31'd0, e_re});
      chk("pc_load_addr", {17'd0, bus.pc_load_addr}, {17'd0, e_load});

      if (!m_halt) begin
         if (m_idle) begin
            m_idle = 1'b0;
            start_req();
         end else if (m_active) begin
            if (m_first) m_addr = m_pc;
            if (rdy) begin
               if (m_doomed || br_v) begin
                  start_req();
               end else begin
                  m_ir     = dat;
                  m_have   = 1'b1;
                  m_active = 1'b0;
               end
            end else if (br_v && m_first) begin
               start_req();
            end else if (!m_first && m_waited == MAX_WAIT) begin
               m_halt   = 1'b1;
               m_err    = 1'b1;
               m_active = 1'b0;
            end else begin
               if (br_v) m_doomed = 1'b1;
               m_first  = 1'b0;
               m_waited = m_waited + 1;
            end
         end else if (m_have && (br_v || ir_ready_v)) begin
            m_have = 1'b0;
            start_req();
         end
      end
      if (e_re)       m_pc = tgt_v;
      else if (e_inc) m_pc = m_pc + 1'b1;

      @(posedge clk); #1;
   endtask

   initial begin
      rst        = 1'b1;
      ir_ready_v = 1'b1;
      br_v       = 1'b0;
      tgt_v      = '0;
      lat_cfg    = 0;
      m_pc       = 15'd5;
      do_reset();

      // zero-wait fetch at PC 5, then one increment
      cycle();
      cycle();
      chk("t1_ir", {16'd0, bus.ir}, 32'h0000A5A5);
      chk("t1_ir_valid", {31'd0, bus.ir_valid}, 32'd1);
      cycle();
      cycle();

      // decode stall
      ir_ready_v = 1'b0;
      repeat (4) cycle();
      chk("t2_ir_held", {16'd0, bus.ir}, {16'd0, mem_word(15'd6)});
      chk("t2_valid_held", {31'd0, bus.ir_valid}, 32'd1);
      ir_ready_v = 1'b1;
      lat_cfg    = 3;
      cycle();

      // three wait cycles
      repeat (4) cycle();
      chk("t3_ir", {16'd0, bus.ir}, {16'd0, mem_word(15'd7)});
      chk("t3_err", {31'd0, bus.fetch_err}, 32'd0);
      cycle();

      // branch while waiting: returning data is discarded
      cycle();
      br_v  = 1'b1;
      tgt_v = 15'h0100;
      cycle();
      br_v = 1'b0;
      cycle();
      lat_cfg = 0;
      cycle();
      chk("t4_ir_kept", {16'd0, bus.ir}, {16'd0, mem_word(15'd7)});
      chk("t4_valid", {31'd0, bus.ir_valid}, 32'd0);
      cycle();
      chk("t4_ir_target", {16'd0, bus.ir}, {16'd0, mem_word(15'h0100)});

      // branch beats a simultaneous handshake
      ir_ready_v = 1'b1;
      br_v       = 1'b1;
      tgt_v      = 15'h0200;
      cycle();
      chk("t5_valid_drop", {31'd0, bus.ir_valid}, 32'd0);
      br_v = 1'b0;
      cycle();

      // memory never answers: timeout, halt ignores branches
      lat_cfg = 99;
      cycle();
      repeat (MAX_WAIT + 1) cycle();
      chk("t6_err", {31'd0, bus.fetch_err}, 32'd1);
      chk("t6_rd", {31'd0, bus.mem_rd}, 32'd0);
      br_v  = 1'b1;
      tgt_v = 15'h0333;
      repeat (3) cycle();
      br_v = 1'b0;
      chk("t6_err_sticky", {31'd0, bus.fetch_err}, 32'd1);

      // reset recovers and fetches from the current PC
      lat_cfg = 2;
      do_reset();
      cycle();
      cycle();
      chk("t7_restart_rd", {31'd0, bus.mem_rd}, 32'd1);
      repeat (4) cycle();

      // PC wrap is transparent
      m_pc    = 15'h7FFF;
      lat_cfg = 0;
      do_reset();
      repeat (4) cycle();
      chk("t8_wrap_ir", {16'd0, bus.ir}, {16'd0, mem_word(15'd0)});

      // random traffic
      repeat (600) begin
         ir_ready_v = ($urandom_range(0, 9) < 7);
         br_v       = ($urandom_range(0, 9) == 0);
         tgt_v      = AW'($urandom);
         lat_cfg    = $urandom_range(0, 4);
         if ($urandom_range(0, 149) == 0) do_reset();
         cycle();
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
`default_nettype wire
